menu_navigator: RTL and testbench
=================================

# menu_navigator

Consumes the one-cycle button event pulses (Previous/Next/Okay/Cancel) produced by the push-button debouncer and turns them into menu state for the TFT43 UI. Maintains a cursor over `NUM_ITEMS` settings and an edit mode for changing the selected setting's value. Delivers committed values downstream over a valid/ready handshake. Requests screen redraws from the renderer with a req/ack pair.

## Interface
- `NUM_ITEMS`, 8: number of menu items, ≥2; `IW = $clog2(NUM_ITEMS)`.
- `VAL_W`, 8: setting value width.
- `VAL_MAX`, 255: highest legal value, ≤ 2^VAL_W−1; the value range is 0..VAL_MAX.
- `EDIT_TIMEOUT`, 800_000_000: idle cycles allowed in EDIT before auto-cancel (10 s at 80 MHz); 0 disables the timeout.
- `clk` in 1: system clock, 80 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: block enable.
- `btn_evt` in 4: one-cycle event pulses; [0] Prev, [1] Next, [2] Okay, [3] Cancel.
- `cursor` out IW: selected item index.
- `editing` out 1: high while in EDIT or COMMIT.
- `edit_value` out VAL_W: value being edited. In BROWSE it shows the stored value of the item under the cursor.
- `cmt_valid` out 1: commit request.
- `cmt_ready` in 1: downstream accepts the commit.
- `cmt_index` out IW: item index being committed.
- `cmt_value` out VAL_W: value being committed.
- `redraw_req` out 1: the screen content has changed.
- `redraw_ack` in 1: the renderer has taken the current state.

## Operation
- **States:** BROWSE, EDIT, COMMIT.
- **Item storage:** internal array `item[NUM_ITEMS]` of VAL_W bits. Reset value is 0. It is written only on a commit handshake.
- **Event priority:** if several `btn_evt` bits are high in one cycle, exactly one event is acted on, in the order Cancel > Okay > Next > Prev. The others are dropped.
- **BROWSE:**
  - Prev: `cursor` −1, wrapping 0 → NUM_ITEMS−1.
  - Next: `cursor` +1, wrapping NUM_ITEMS−1 → 0.
  - Okay: load `edit_value` ← `item[cursor]`, go to EDIT.
  - Cancel: `cursor` ← 0.
- **EDIT:**
  - Prev: `edit_value` −1, wrapping 0 → VAL_MAX.
  - Next: `edit_value` +1, wrapping VAL_MAX → 0.
  - Okay: set `cmt_index` = `cursor`, `cmt_value` = `edit_value`, `cmt_valid` = 1, go to COMMIT.
  - Cancel: discard the edit, go to BROWSE. `edit_value` ← `item[cursor]`.
- **Edit timeout:** an idle counter runs only in EDIT and clears on any accepted event. When it reaches EDIT_TIMEOUT, the block behaves exactly as for Cancel.
- **COMMIT:**
  - `cmt_valid`, `cmt_index` and `cmt_value` stay stable until `cmt_valid` && `cmt_ready`.
  - On that handshake cycle: `item[cmt_index]` ← `cmt_value`, `cmt_valid` ← 0, go to BROWSE.
  - All button events are dropped while in COMMIT.
- **Redraw:**
  - `redraw_req` is set on any change of `cursor`, `editing` or `edit_value`.
  - It is cleared on a cycle with `redraw_ack` and no new change.
  - If a change and `redraw_ack` occur in the same cycle, `redraw_req` stays 1.
- **`en` low:**
  - Synchronous abort to BROWSE: `cmt_valid` ← 0, idle counter ← 0, events ignored.
  - `cursor` and `item[]` are retained.
  - An abort during COMMIT drops the commit without writing `item[]`. This is the only permitted withdrawal of `cmt_valid`.

## Timing
- **Reset values:** state BROWSE; `cursor` 0; `editing` 0; `edit_value` 0; `cmt_valid` 0; `cmt_index` 0; `cmt_value` 0; `redraw_req` 1, so the first frame is drawn after reset.
- **Output registers:** all outputs are registered. An event in cycle N is visible at edge N+1.
- **`redraw_req` latency:** `redraw_req` rises at the same edge as the change that caused it.
- **Commit handshake:** if `cmt_ready` is already high, the handshake completes 1 cycle after `cmt_valid` rises. The state is back in BROWSE with `editing` = 0 at that same edge.
- **Event after commit:** a button event arriving in the handshake cycle is dropped. An event one cycle later is processed in BROWSE.
- **Timeout:** with no events, EDIT exits exactly EDIT_TIMEOUT+1 cycles after entry.
- **Combinational paths:** there is no path from input to output. `cmt_ready` and `redraw_ack` are sampled only.

## Structure
- **Package `menu_pkg`:**
  - state enum {BROWSE, EDIT, COMMIT};
  - button bit index constants BTN_PREV=0, BTN_NEXT=1, BTN_OK=2, BTN_CANCEL=3.
- **Sub-module `wrap_counter`:**
  - parameters WIDTH, MAX;
  - inputs load, load_val, inc, dec;
  - wraps at 0/MAX.
  - Instantiate it twice, for `cursor` and `edit_value`.
- **Top level:** the FSM, item array, idle counter and redraw flag.

## Test plan
Bench parameters: NUM_ITEMS=4, VAL_MAX=9, EDIT_TIMEOUT=100.
- **Cursor wrap:** after reset, Prev → `cursor` 3; Next ×2 → `cursor` 1; Cancel → `cursor` 0.
- **Edit and commit:** Okay, then Prev → `edit_value` 9. Okay with `cmt_ready` low for 5 cycles → `cmt_valid` held with index 0 / value 9 and events ignored. Raise `cmt_ready` → `item[0]` = 9, BROWSE, `edit_value` 9.
- **Simultaneous events:** `btn_evt` = 4'b1110 in BROWSE → only Cancel is taken; `cursor` 0, state unchanged.
- **Timeout:** enter EDIT, press Next once, then idle → return to BROWSE exactly 101 cycles after the Next; `edit_value` is restored and `item[]` is unchanged.
- **Redraw:** hold `redraw_ack` low, press Next → `redraw_req` 1. Pulse `redraw_ack` in the same cycle as a Next → `redraw_req` stays 1. Pulse `redraw_ack` alone → `redraw_req` 0.
- **Aborts:**
  - Drop `en` during COMMIT → `cmt_valid` 0 next cycle, `item[]` unwritten, `cursor` retained.
  - Assert `rst_n` mid-EDIT → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared types and constants for the TFT43 menu navigator.
package menu_pkg;

   typedef enum logic [1:0] {
      BROWSE = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int BTN_PREV   = 0;
   localparam int BTN_NEXT   = 1;
   localparam int BTN_OK     = 2;
   localparam int BTN_CANCEL = 3;

endpackage

// File: rtl/menu_navigator_wrap_counter.sv
// Up/down counter over 0..MAX that wraps at both ends; load has priority over inc, inc over dec.
// Exposes its next value so the owner can detect changes in the same cycle.
module wrap_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] d
);

   always_comb begin
      d = q;
      if (load) begin
         d = load_val;
      end else if (inc) begin
         d = (q == WIDTH'(MAX)) ? '0 : q + 1'b1;
      end else if (dec) begin
         d = (q == '0) ? WIDTH'(MAX) : q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/menu_navigator.sv
// Turns debounced button pulses into menu cursor/edit state, commits values over valid/ready
// and raises a redraw request on every visible change. All outputs are registered.
module menu_navigator
   import menu_pkg::*;
#(
   parameter int NUM_ITEMS    = 8,
   parameter int VAL_W        = 8,
   parameter int VAL_MAX      = 255,
   parameter int EDIT_TIMEOUT = 800_000_000,
   localparam int IW          = $clog2(NUM_ITEMS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       btn_evt,
   output logic [IW-1:0]    cursor,
   output logic             editing,
   output logic [VAL_W-1:0] edit_value,
   output logic             cmt_valid,
   input  logic             cmt_ready,
   output logic [IW-1:0]    cmt_index,
   output logic [VAL_W-1:0] cmt_value,
   output logic             redraw_req,
   input  logic             redraw_ack
);

   localparam int TW = (EDIT_TIMEOUT > 0) ? $clog2(EDIT_TIMEOUT + 1) : 1;

   state_t           state, state_d;
   logic [VAL_W-1:0] item [NUM_ITEMS];
   logic [TW-1:0]    idle;

   logic ev_prev, ev_next, ev_ok, ev_cancel, ev_any;
   logic timeout, handshake, change;
   logic cur_load, cur_inc, cur_dec;
   logic val_load, val_inc, val_dec;
   logic [IW-1:0]    cur_d;
   logic [VAL_W-1:0] val_d;
   logic [VAL_W-1:0] val_load_val;

   // One event per cycle: Cancel > Okay > Next > Prev.
   assign ev_cancel = en & btn_evt[BTN_CANCEL];
   assign ev_ok     = en & btn_evt[BTN_OK] & ~btn_evt[BTN_CANCEL];
   assign ev_next   = en & btn_evt[BTN_NEXT] & ~btn_evt[BTN_OK] & ~btn_evt[BTN_CANCEL];
   assign ev_prev   = en & btn_evt[BTN_PREV] & ~(|btn_evt[3:1]);
   assign ev_any    = ev_prev | ev_next | ev_ok | ev_cancel;

   assign timeout   = (EDIT_TIMEOUT != 0) && (state == EDIT) && (idle == TW'(EDIT_TIMEOUT));
   assign handshake = en && cmt_valid && cmt_ready;

   // Outside an edit the displayed value tracks the stored value under the (next) cursor.
   assign val_load_val = item[cur_d];

   always_comb begin
      state_d  = state;
      cur_load = 1'b0;
      cur_inc  = 1'b0;
      cur_dec  = 1'b0;
      val_load = 1'b0;
      val_inc  = 1'b0;
      val_dec  = 1'b0;
      case (state)
         BROWSE: begin
            cur_load = ev_cancel;
            cur_inc  = ev_next;
            cur_dec  = ev_prev;
            val_load = 1'b1;
            if (ev_ok) state_d = EDIT;
         end
         EDIT: begin
            if (timeout || ev_cancel) begin
               state_d  = BROWSE;
               val_load = 1'b1;
            end else if (ev_ok) begin
               state_d = COMMIT;
            end else begin
               val_inc = ev_next;
               val_dec = ev_prev;
            end
         end
         COMMIT: begin
            if (handshake) state_d = BROWSE;
         end
         default: state_d = BROWSE;
      endcase
      if (!en) begin
         state_d  = BROWSE;
         val_load = 1'b1;
      end
   end

   assign change = (cur_d != cursor) || (val_d != edit_value) ||
                   ((state_d != BROWSE) != editing);

   wrap_counter #(.WIDTH(IW), .MAX(NUM_ITEMS - 1)) u_cursor (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cur_load),
      .load_val ({IW{1'b0}}),
      .inc      (cur_inc),
      .dec      (cur_dec),
      .q        (cursor),
      .d        (cur_d)
   );

   wrap_counter #(.WIDTH(VAL_W), .MAX(VAL_MAX)) u_value (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (val_load),
      .load_val (val_load_val),
      .inc      (val_inc),
      .dec      (val_dec),
      .q        (edit_value),
      .d        (val_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BROWSE;
         editing    <= 1'b0;
         cmt_valid  <= 1'b0;
         cmt_index  <= '0;
         cmt_value  <= '0;
         idle       <= '0;
         redraw_req <= 1'b1;
         for (int i = 0; i < NUM_ITEMS; i++) item[i] <= '0;
      end else begin
         state     <= state_d;
         editing   <= (state_d != BROWSE);
         cmt_valid <= (state_d == COMMIT);
         if (state == EDIT && state_d == COMMIT) begin
            cmt_index <= cursor;
            cmt_value <= edit_value;
         end
         if (handshake) item[cmt_index] <= cmt_value;
         if (state_d == EDIT && !ev_any && EDIT_TIMEOUT != 0) idle <= idle + 1'b1;
         else idle <= '0;
         if (change) redraw_req <= 1'b1;
         else if (redraw_ack) redraw_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_menu_navigator.sv
// Directed plus random stimulus against a behavioural model of the menu navigator.
module tb_menu_navigator;

   localparam int NI   = 4;
   localparam int VMAX = 9;
   localparam int TO   = 100;
   localparam int IW   = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b1;
   logic [3:0]   btn_evt = '0;
   logic [IW-1:0] cursor;
   logic         editing;
   logic [7:0]   edit_value;
   logic         cmt_valid;
   logic         cmt_ready = 1'b0;
   logic [IW-1:0] cmt_index;
   logic [7:0]   cmt_value;
   logic         redraw_req;
   logic         redraw_ack = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Model state: mode 0 browse, 1 edit, 2 commit.
   int m_mode, m_cur, m_val, m_idle, m_cidx, m_cval;
   bit m_red;
   int m_item [NI];

   menu_navigator #(.NUM_ITEMS(NI), .VAL_W(8), .VAL_MAX(VMAX), .EDIT_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .btn_evt    (btn_evt),
      .cursor     (cursor),
      .editing    (editing),
      .edit_value (edit_value),
      .cmt_valid  (cmt_valid),
      .cmt_ready  (cmt_ready),
      .cmt_index  (cmt_index),
      .cmt_value  (cmt_value),
      .redraw_req (redraw_req),
      .redraw_ack (redraw_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cur = 0; m_val = 0; m_idle = 0; m_cidx = 0; m_cval = 0; m_red = 1'b1;
      for (int i = 0; i < NI; i++) m_item[i] = 0;
   endtask

   task automatic model_step(input logic [3:0] b, input logic e, input logic r, input logic a);
      int ev, ncur, nval, nmode;
      ev = b[3] ? 4 : b[2] ? 3 : b[1] ? 2 : b[0] ? 1 : 0;
      ncur = m_cur; nval = m_val; nmode = m_mode;
      if (!e) begin
         nmode = 0; nval = m_item[m_cur]; m_idle = 0;
      end else begin
         case (m_mode)
            0: begin
               if (ev == 1) ncur = (m_cur + NI - 1) % NI;
               else if (ev == 2) ncur = (m_cur + 1) % NI;
               else if (ev == 4) ncur = 0;
               else if (ev == 3) nmode = 1;
               nval = m_item[ncur];
               m_idle = 0;
            end
            1: begin
               if (ev == 4 || m_idle == TO) begin
                  nmode = 0; nval = m_item[m_cur]; m_idle = 0;
               end else if (ev == 3) begin
                  nmode = 2; m_cidx = m_cur; m_cval = m_val; m_idle = 0;
               end else if (ev == 2) begin
                  nval = (m_val + 1) % (VMAX + 1); m_idle = 0;
               end else if (ev == 1) begin
                  nval = (m_val + VMAX) % (VMAX + 1); m_idle = 0;
               end else begin
                  m_idle++;
               end
            end
            default: begin
               if (r) begin
                  m_item[m_cidx] = m_cval; nmode = 0;
               end
            end
         endcase
      end
      if (ncur != m_cur || nval != m_val || ((nmode != 0) != (m_mode != 0))) m_red = 1'b1;
      else if (a) m_red = 1'b0;
      m_cur = ncur; m_val = nval; m_mode = nmode;
   endtask

   task automatic compare_all();
      chk("cursor", 32'(cursor), 32'(m_cur));
      chk("editing", 32'(editing), 32'(m_mode != 0));
      chk("edit_value", 32'(edit_value), 32'(m_val));
      chk("cmt_valid", 32'(cmt_valid), 32'(m_mode == 2));
      chk("cmt_index", 32'(cmt_index), 32'(m_cidx));
      chk("cmt_value", 32'(cmt_value), 32'(m_cval));
      chk("redraw_req", 32'(redraw_req), 32'(m_red));
   endtask

   task automatic step(input logic [3:0] b, input logic e, input logic r, input logic a);
      btn_evt = b; en = e; cmt_ready = r; redraw_ack = a;
      @(posedge clk);
      model_step(b, e, r, a);
      #1;
      compare_all();
      btn_evt = '0; redraw_ack = 1'b0;
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      #2 rst_n = 1'b1;

      // Cursor wrap
      step(4'b0001, 1, 0, 0); chk("wrap_prev", 32'(cursor), 3);
      step(4'b0010, 1, 0, 0);
      step(4'b0010, 1, 0, 0); chk("wrap_next", 32'(cursor), 1);
      step(4'b1000, 1, 0, 0); chk("cancel_home", 32'(cursor), 0);

      // Edit and commit with a stalled consumer
      step(4'b0100, 1, 0, 0); chk("enter_edit", 32'(editing), 1);
      step(4'b0001, 1, 0, 0); chk("value_wrap", 32'(edit_value), 9);
      step(4'b0100, 1, 0, 0); chk("cmt_raise", 32'(cmt_valid), 1);
      chk("cmt_idx0", 32'(cmt_index), 0); chk("cmt_val9", 32'(cmt_value), 9);
      repeat (5) begin
         step(4'($urandom_range(1, 15)), 1, 0, 0);
         chk("cmt_hold", 32'(cmt_valid), 1);
      end
      step(4'b0000, 1, 1, 0); chk("cmt_done_browse", 32'(editing), 0);
      chk("cmt_done_val", 32'(edit_value), 9);

      // Simultaneous events: only Cancel taken
      step(4'b0010, 1, 0, 0);
      step(4'b1110, 1, 0, 0); chk("multi_cursor", 32'(cursor), 0);
      chk("multi_state", 32'(editing), 0);

      // Timeout after one edit step
      step(4'b0100, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      n = 0;
      do begin
         step(4'b0000, 1, 0, 0);
         n++;
      end while (editing && n < 200);
      chk("timeout_cycles", 32'(n), 101);
      chk("timeout_restore", 32'(edit_value), 9);

      // Redraw handshake
      step(4'b0000, 1, 0, 1); chk("redraw_clear", 32'(redraw_req), 0);
      step(4'b0010, 1, 0, 0); chk("redraw_set", 32'(redraw_req), 1);
      step(4'b0010, 1, 0, 1); chk("redraw_ack_chg", 32'(redraw_req), 1);
      step(4'b0000, 1, 0, 1); chk("redraw_ack_only", 32'(redraw_req), 0);

      // Abort a pending commit by dropping en
      step(4'b0100, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      step(4'b0100, 1, 0, 0);
      step(4'b0000, 0, 0, 0); chk("abort_valid", 32'(cmt_valid), 0);
      chk("abort_cursor", 32'(cursor), 2);
      step(4'b0000, 1, 0, 0);

      // Asynchronous reset mid-edit
      step(4'b0100, 1, 0, 0);
      step(4'b0010, 1, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_cursor", 32'(cursor), 0);
      chk("arst_editing", 32'(editing), 0);
      chk("arst_value", 32'(edit_value), 0);
      chk("arst_valid", 32'(cmt_valid), 0);
      chk("arst_index", 32'(cmt_index), 0);
      chk("arst_cval", 32'(cmt_value), 0);
      chk("arst_redraw", 32'(redraw_req), 1);
      model_reset();
      #2 rst_n = 1'b1;

      // Random traffic: busy phase, then sparse phase that lets timeouts fire
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
              $urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 149) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
              $urandom_range(0, 999) != 0, $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
